adc_capture_ctrl: RTL
=====================

// Module: adc_capture_ctrl
// PURPOSE
//  Acquisition controller between the AD9244 14-bit ADC pins and the ADC sample RAM write port.
//  On a start request it discards the ADC pipeline-latency samples, decimates the stream and
//  writes exactly DEPTH samples to RAM addresses 0..DEPTH-1.
//  It then raises done, which tells the UART/FFT readers that the buffer is complete.
// PARAMETERS
//  ND_ADC    14   ADC sample width / RAM data width
//  NA_ADC    8    RAM address width
//  DEPTH     256  samples per capture, must be <= 2**NA_ADC
//  PIPE_LAT  8    ADC pipeline latency in clk cycles; samples discarded after start
//  DIV_W     16   width of decimation control
// PORTS
//  clk        in   1       system clock; ADC is sampled on the same clock
//  rst        in   1       asynchronous reset, active high
//  start      in   1       1-cycle capture request; honoured only in IDLE or DONE
//  abort      in   1       cancel an in-progress capture
//  decim      in   DIV_W   keep 1 sample every decim+1 cycles; latched at start
//  adc_data   in   ND_ADC  AD9244 output word
//  adc_otr    in   1       AD9244 out-of-range flag
//  ram_data   out  ND_ADC  RAM write data
//  ram_addr   out  NA_ADC  RAM write address
//  ram_we     out  1       RAM write enable, active high
//  busy       out  1       high in FLUSH or CAPT
//  done       out  1       high in DONE; buffer valid
//  otr_seen   out  1       sticky: an out-of-range sample was written in this capture
// BEHAVIOUR
//  Reset values: ram_data=0, ram_addr=0, ram_we=0, busy=0, done=0, otr_seen=0; state=IDLE.
//  Input stage: adc_data and adc_otr are registered once (data_q, otr_q) on every clk.
//  FSM states: IDLE, FLUSH, CAPT, DONE.
//   IDLE  -> FLUSH on start.
//         On that edge: decim is latched into dec_r; flush_cnt=0, div_cnt=0, addr=0, otr_seen=0.
//   DONE  -> FLUSH on start, with the same actions as IDLE; done drops in that same cycle.
//   FLUSH -> CAPT when flush_cnt reaches PIPE_LAT-1 (exactly PIPE_LAT cycles spent in FLUSH).
//         No writes occur in FLUSH.
//   CAPT  -> writes data_q each time div_cnt==0; div_cnt counts 0..dec_r and wraps to 0.
//         The first write happens on the first CAPT cycle.
//         Each write registers: ram_we=1, ram_addr=addr, ram_data=data_q, otr_seen|=otr_q.
//         addr increments after each write.
//         After the write to address DEPTH-1: next state DONE; addr does not wrap and
//         address 0 is never rewritten.
//   DONE  -> holds done=1 until start; ram_we=0.
//  ram_we: registered, high for exactly one cycle per write, otherwise 0.
//   ram_addr and ram_data hold their last values while ram_we=0.
//  Capture length:
//   decim=0 -> DEPTH consecutive writes; total start-to-done latency = 1+PIPE_LAT+DEPTH cycles.
//   decim=k -> writes spaced k+1 cycles apart.
//  abort: in FLUSH or CAPT -> IDLE next cycle. No further writes, done stays 0, otr_seen holds.
//   abort is ignored in IDLE and DONE.
//  Simultaneous start+abort: abort wins in FLUSH/CAPT; start wins in IDLE/DONE.
//  start while busy is ignored.
//  Changes on decim during a capture have no effect until the next start.
//  Async rst mid-capture: all outputs go to reset values immediately; state=IDLE;
//   the partial RAM content is undefined to consumers (done=0).
//  Counters: flush_cnt is clog2(PIPE_LAT)+1 bits; div_cnt is DIV_W bits; addr is NA_ADC+1 bits
//   so that the terminal count is detected without overflow.
// TESTING
//  1 Reset: assert rst mid-CAPT -> all outputs 0 the same cycle; after release, IDLE, no writes.
//  2 decim=0, adc_data=ramp n, start -> 8 cycles with no we, then 256 consecutive we at
//    addr 0..255, data follows the ramp (1-cycle register); done at cycle 265; busy=0.
//  3 decim=3 -> we every 4th cycle, 256 writes, last addr 255; change decim to 0 mid-capture
//    -> spacing unchanged.
//  4 adc_otr=1 for one sampled cycle only -> otr_seen=1 from that write through DONE;
//    cleared by the next start.
//  5 abort at write #100 -> no we after abort, done=0, busy=0; start+abort in the same cycle
//    during CAPT -> abort wins.
//  6 start pulses while busy -> ignored (write count still 256);
//    start in DONE -> done drops, a new capture restarts at addr 0.

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: flushes AD9244 pipeline latency, decimates the sample stream and fills the sample RAM
module adc_capture_ctrl #(
    parameter int ND_ADC   = 14,
    parameter int NA_ADC   = 8,
    parameter int DEPTH    = 256,
    parameter int PIPE_LAT = 8,
    parameter int DIV_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DIV_W-1:0]  i_decim,
    input  logic [ND_ADC-1:0] i_adc_data,
    input  logic              i_adc_otr,
    output logic [ND_ADC-1:0] o_ram_data,
    output logic [NA_ADC-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_otr_seen
);
    localparam int FW = $clog2(PIPE_LAT) + 1;
    localparam int AW = NA_ADC + 1;

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_CAPT, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ND_ADC-1:0]  r_data_q;
    logic               r_otr_q;
    logic [DIV_W-1:0]   r_dec;
    logic [DIV_W-1:0]   r_div;
    logic [FW-1:0]      r_flush;
    logic [AW-1:0]      r_addr;
    logic [ND_ADC-1:0]  r_ram_data;
    logic [NA_ADC-1:0]  r_ram_addr;
    logic               r_ram_we;
    logic               r_otr_seen;
    logic               w_go;
    logic               w_kill;
    logic               w_wr;
    logic               w_last;

    assign w_go   = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_kill = i_abort && (r_state == S_FLUSH || r_state == S_CAPT);
    assign w_wr   = r_state == S_CAPT && r_div == '0 && !i_abort;
    assign w_last = w_wr && r_addr == AW'(DEPTH - 1);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // next state: start beats abort outside a capture, abort beats everything inside one
    always_comb begin
        w_next = w_go ? S_FLUSH :
                 w_kill ? S_IDLE :
                 (r_state == S_FLUSH && r_flush == FW'(PIPE_LAT - 1)) ? S_CAPT :
                 w_last ? S_DONE : r_state;
    end

    // status outputs decoded from state so they track reset and transitions exactly
    always_comb begin
        o_busy = r_state == S_FLUSH || r_state == S_CAPT;
        o_done = r_state == S_DONE;
    end

    // ADC input stage, flush/decimation/address counters and the registered RAM write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_q   <= '0;
            r_otr_q    <= 1'b0;
            r_dec      <= '0;
            r_div      <= '0;
            r_flush    <= '0;
            r_addr     <= '0;
            r_ram_data <= '0;
            r_ram_addr <= '0;
            r_ram_we   <= 1'b0;
            r_otr_seen <= 1'b0;
        end else begin
            r_data_q <= i_adc_data;
            r_otr_q  <= i_adc_otr;
            r_ram_we <= w_wr;
            if (w_go) begin
                r_dec      <= i_decim;
                r_div      <= '0;
                r_flush    <= '0;
                r_addr     <= '0;
                r_otr_seen <= 1'b0;
            end else begin
                if (r_state == S_FLUSH) r_flush <= r_flush + 1'b1;
                if (r_state == S_CAPT) r_div <= (r_div == r_dec) ? '0 : r_div + 1'b1;
                if (w_wr) begin
                    r_addr     <= r_addr + 1'b1;
                    r_ram_addr <= r_addr[NA_ADC-1:0];
                    r_ram_data <= r_data_q;
                    r_otr_seen <= r_otr_seen | r_otr_q;
                end
            end
        end
    end

    assign o_ram_data = r_ram_data;
    assign o_ram_addr = r_ram_addr;
    assign o_ram_we   = r_ram_we;
    assign o_otr_seen = r_otr_seen;
endmodule
